// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_packer
// Brief    : Drains a byte FIFO and packs LANES bytes little-endian into one
//            word on a valid/ready stream; flush emits a trailing partial word.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    input  logic [DATA_W-1:0]        fifo_dout,
    output logic                     fifo_rd_en,
    input  logic                     flush,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W*LANES-1:0]  m_data,
    output logic [LANES-1:0]         m_keep
);

    localparam int                CNT_W       = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0]  C_LANES     = CNT_W'(LANES);
    localparam logic [CNT_W-1:0]  C_LAST_LANE = CNT_W'(LANES - 1);
    localparam logic [CNT_W:0]    C_LANES_EXT = (CNT_W + 1)'(LANES);

    logic                     r_pend;
    logic [CNT_W-1:0]         r_cnt;
    logic [DATA_W*LANES-1:0]  r_pack;
    logic [LANES-1:0]         r_stage_keep;

    logic [CNT_W:0]           w_fill;
    logic                     w_xfer;
    logic                     w_flush;
    logic [LANES-1:0]         w_lane_hit;
    logic [LANES-1:0]         w_low_mask;
    logic [DATA_W*LANES-1:0]  w_pack_next;

    // Bytes already held plus the one in flight bound further pops.
    assign w_fill     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_pend};
    assign fifo_rd_en = !rst && !fifo_empty && (w_fill < C_LANES_EXT);

    assign w_xfer  = (r_cnt == C_LANES) && (!m_valid || m_ready);
    assign w_flush = flush && fifo_empty && !r_pend &&
                     (r_cnt != '0) && (r_cnt < C_LANES);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_lane_hit[gi] = (r_cnt == CNT_W'(gi));
            assign w_low_mask[gi] = (r_cnt > CNT_W'(gi));
        end
    endgenerate

    always_comb begin
        w_pack_next = r_pack;
        if (w_xfer) begin
            w_pack_next = '0;
        end else if (r_pend) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_lane_hit[i]) begin
                    w_pack_next[i*DATA_W +: DATA_W] = fifo_dout;
                end
            end
        end else if (w_flush) begin
            for (int i = 0; i < LANES; i++) begin
                if (!w_low_mask[i]) begin
                    w_pack_next[i*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend       <= 1'b0;
            r_cnt        <= '0;
            r_pack       <= '0;
            r_stage_keep <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_keep       <= '0;
        end else begin
            r_pend <= fifo_rd_en;
            r_pack <= w_pack_next;
            // Staged word (cnt==LANES) never coincides with a pending capture.
            if (w_xfer) begin
                r_cnt   <= '0;
                m_data  <= r_pack;
                m_keep  <= r_stage_keep;
                m_valid <= 1'b1;
            end else begin
                if (m_valid && m_ready) begin
                    m_valid <= 1'b0;
                end
                if (r_pend) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST_LANE) begin
                        r_stage_keep <= '1;
                    end
                end else if (w_flush) begin
                    r_cnt        <= C_LANES;
                    r_stage_keep <= w_low_mask;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_packer
// Brief    : Directed bench for fifo_rd_packer with a behavioural byte FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    fifo_empty;
    logic [DATA_W-1:0]       fifo_dout = '0;
    logic                    fifo_rd_en;
    logic                    flush = 1'b0;
    logic                    m_valid;
    logic                    m_ready = 1'b0;
    logic [DATA_W*LANES-1:0] m_data;
    logic [LANES-1:0]        m_keep;

    fifo_rd_packer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data, emptied by reset.
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] hs_data [$];
    logic [3:0]  hs_keep [$];
    int          hs_cyc  [$];
    int          pop_cnt  = 0;
    int          rden_cnt = 0;
    int          vld_cnt  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                hs_data.push_back(m_data);
                hs_keep.push_back(m_keep);
                hs_cyc.push_back(cyc);
            end
            if (fifo_rd_en && !fifo_empty) pop_cnt <= pop_cnt + 1;
            if (fifo_rd_en) rden_cnt <= rden_cnt + 1;
            if (m_valid) vld_cnt <= vld_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic wait_hs(input string name, input int target, input int budget);
        int k = 0;
        while (hs_data.size() < target && k < budget) begin
            tick(1);
            k++;
        end
        if (hs_data.size() < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout, got %0d words expected %0d", name, hs_data.size(), target);
        end
    endtask

    function automatic logic [31:0] word_at(input int idx);
        if (idx < hs_data.size()) return hs_data[idx];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] keep_at(input int idx);
        if (idx < hs_keep.size()) return {28'd0, hs_keep[idx]};
        return 32'hxxxx_xxxx;
    endfunction

    typedef struct {
        int          n;
        logic [31:0] din;
        logic        fl;
        logic [31:0] exp_d;
        logic [3:0]  exp_k;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, p0, v0, r0;
        logic [31:0] din;

        vecs[0] = '{4, 32'h4433_2211, 1'b0, 32'h4433_2211, 4'b1111};
        vecs[1] = '{2, 32'h0000_B2A1, 1'b1, 32'h0000_B2A1, 4'b0011};
        vecs[2] = '{1, 32'h0000_005A, 1'b1, 32'h0000_005A, 4'b0001};
        vecs[3] = '{3, 32'h0003_0201, 1'b1, 32'h0003_0201, 4'b0111};
        vecs[4] = '{4, 32'hEFBE_ADDE, 1'b0, 32'hEFBE_ADDE, 4'b1111};

        // Reset state, with the FIFO non-empty while reset is held.
        tick(2);
        push(8'h99);
        #2;
        chk("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("reset_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_data", m_data, 32'd0);
        chk("reset_keep", {28'd0, m_keep}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Table-driven packing and flush.
        for (int i = 0; i < 5; i++) begin
            base = hs_data.size();
            p0 = pop_cnt;
            v0 = vld_cnt;
            m_ready = 1'b1;
            flush = vecs[i].fl;
            din = vecs[i].din;
            for (int j = 0; j < vecs[i].n; j++) push(din[j*8 +: 8]);
            wait_hs($sformatf("vec%0d_word", i), base + 1, 40);
            tick(8);
            flush = 1'b0;
            chk($sformatf("vec%0d_data", i), word_at(base), vecs[i].exp_d);
            chk($sformatf("vec%0d_keep", i), keep_at(base), {28'd0, vecs[i].exp_k});
            chk($sformatf("vec%0d_nwords", i), hs_data.size() - base, 32'd1);
            chk($sformatf("vec%0d_pops", i), pop_cnt - p0, vecs[i].n);
            chk($sformatf("vec%0d_vcycles", i), vld_cnt - v0, 32'd1);
        end

        // Backpressure: 12 bytes, consumer stalled for 20 cycles.
        m_ready = 1'b0;
        base = hs_data.size();
        p0 = pop_cnt;
        for (int k = 0; k < 12; k++) push(8'(k));
        tick(20);
        chk("bp_pops_stalled", pop_cnt - p0, 32'd8);
        chk("bp_valid_held", {31'd0, m_valid}, 32'd1);
        chk("bp_data_held", m_data, 32'h0302_0100);
        chk("bp_no_hs", hs_data.size() - base, 32'd0);
        m_ready = 1'b1;
        wait_hs("bp_words", base + 3, 60);
        tick(5);
        chk("bp_word0", word_at(base), 32'h0302_0100);
        chk("bp_word1", word_at(base + 1), 32'h0706_0504);
        chk("bp_word2", word_at(base + 2), 32'h0B0A_0908);
        chk("bp_pops_total", pop_cnt - p0, 32'd12);

        // Empty FIFO: no reads, no words; then sparse pushes.
        v0 = vld_cnt;
        r0 = rden_cnt;
        tick(10);
        chk("empty_rd_en", rden_cnt - r0, 32'd0);
        chk("empty_valid", vld_cnt - v0, 32'd0);
        base = hs_data.size();
        for (int k = 0; k < 8; k++) begin
            push(8'h80 + 8'(k));
            tick(3);
        end
        wait_hs("sparse_words", base + 2, 40);
        chk("sparse_word0", word_at(base), 32'h8382_8180);
        chk("sparse_word1", word_at(base + 1), 32'h8786_8584);

        // Asynchronous reset with two bytes captured and one in flight.
        tick(3);
        for (int k = 0; k < 4; k++) push(8'hE0 + 8'(k));
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        chk("amid_valid", {31'd0, m_valid}, 32'd0);
        chk("amid_data", m_data, 32'd0);
        chk("amid_keep", {28'd0, m_keep}, 32'd0);
        chk("amid_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        base = hs_data.size();
        for (int k = 0; k < 4; k++) push(8'hC1 + 8'(k));
        wait_hs("post_rst_word", base + 1, 40);
        tick(3);
        chk("post_rst_data", word_at(base), 32'hC4C3_C2C1);
        chk("post_rst_keep", keep_at(base), 32'hF);
        chk("post_rst_nwords", hs_data.size() - base, 32'd1);

        // Throughput with a continuously non-empty FIFO.
        base = hs_data.size();
        for (int k = 0; k < 24; k++) push(8'h10 + 8'(k));
        wait_hs("tput_words", base + 6, 100);
        for (int j = 1; j < 6; j++) begin
            if (base + j < hs_cyc.size())
                chk($sformatf("tput_gap%0d", j), hs_cyc[base + j] - hs_cyc[base + j - 1], 32'd6);
        end
        chk("tput_first", word_at(base), 32'h1312_1110);
        chk("tput_last", word_at(base + 5), 32'h2726_2524);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
